mult_share_arb: RTL and testbench
=================================

Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined signed multiplier (basic_mult) among NREQ requesters.
- Drives the multiplier's ce/ain/bin, tracks in-flight operations with a requester-ID tag pipeline matched to the multiplier latency, and returns each product tagged with its requester ID.
- Applies result backpressure by freezing the multiplier through ce.
- Sits between requester datapaths and the basic_mult instance.

Parameters:
- AW, 27, signed operand A width
- BW, 18, signed operand B width
- NREQ, 4, number of requesters (2..8)
- LAT, 3, number of ce-qualified register stages from ain/bin to prod in the multiplier (1..8)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester operation request
- req_ready  output  NREQ  per-requester grant; transfer when valid&ready
- req_a  input  NREQ*AW  packed signed A operands; requester i at [i*AW +: AW]
- req_b  input  NREQ*BW  packed signed B operands; requester i at [i*BW +: BW]
- m_ce  output  1  multiplier clock enable
- m_ain  output  AW  multiplier A input
- m_bin  output  BW  multiplier B input
- m_prod  input  AW+BW  multiplier product
- res_valid  output  1  result valid
- res_ready  input  1  result consumer ready
- res_id  output  $clog2(NREQ)  requester ID of the result
- res_prod  output  AW+BW  signed product, equal to m_prod
- stall_cnt  output  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): tag-valid pipeline cleared, rr pointer=0, stall_cnt=0.
  - Outputs during reset: res_valid=0, req_ready=0, m_ce=0, m_ain=0, m_bin=0, res_id=0.
  - Multiplier contents are not reset; in-flight operations are discarded by clearing their tag valids.
- Stall rule: stall = res_valid & ~res_ready. m_ce = rst_n_sync_released & ~stall, i.e. m_ce=1 every cycle out of reset except during a stall.
  - m_ce also clocks bubbles through the multiplier when no request is pending.
- Arbitration, combinational each cycle with m_ce=1:
  - Grant the first requester with req_valid high, searching from index ptr upward with wrap.
  - req_ready = one-hot grant, gated by m_ce. No grant when no valid or when stalled.
- On grant to requester g:
  - m_ain = req_a[g] and m_bin = req_b[g]. With no grant, m_ain=0 and m_bin=0.
  - Tag stage 0 loads {valid=1, id=g} at the clock edge. ptr <= (g+1) mod NREQ.
- No grant: tag stage 0 loads valid=0. ptr is unchanged.
- Tag pipeline: LAT stages of {valid, id}; advances only when m_ce=1 and holds when m_ce=0, exactly like the multiplier.
  - res_valid = last-stage valid; res_id = last-stage id; res_prod = m_prod (pass-through).
- Latency: product appears on res_* exactly LAT m_ce-enabled edges after the grant cycle. With no stalls, a grant in cycle t produces res_valid in cycle t+LAT.
- Throughput: one issue per non-stalled cycle. Results are delivered in issue order.
- Result handshake: a result is consumed on res_valid&res_ready.
  - While stalled, res_valid, res_id and res_prod hold stable and no new grant occurs.
- Requesters hold req_a/req_b stable while req_valid=1 until accepted. A valid may be withdrawn only when ready is low.
- Fairness: a requester continuously valid is granted at least once every NREQ grants.
- Simultaneous stall release and new requests: grant occurs in the same cycle res_ready rises.
- Signed arithmetic only; no truncation. res_prod is full AW+BW width.

Optional Feature:
- Macro MULT_SHARE_ARB_STATS_EN.
- Defined: stall_cnt increments by 1 every cycle with stall=1 while any req_valid is high. It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Not defined: stall_cnt is tied to 0 and no counter logic is synthesized.

Test Plan:
- Single requester, back-to-back: req 0 valid for 4 cycles with (a,b)=(3,-4),(−10,10),(7,7),(0,5), res_ready=1 -> res_prod −12,−100,49,0, all id=0, each LAT=3 cycles after grant, 4 consecutive res_valid cycles.
- All 4 requesters valid continuously, a=i+1, b=−2 -> grants 0,1,2,3,0,… one per cycle. res_id sequence 0,1,2,3 with prod −2,−4,−6,−8.
- Backpressure: res_ready=0 for 5 cycles while a result is valid -> m_ce=0, req_ready=0, and res_* stable. After release, all results arrive in order with none lost or duplicated. stall_cnt=5 with macro, 0 without.
- Wrap/fairness: ptr=3 with requesters 1 and 3 valid -> grant 3, then 1, then 3.
- Extremes: a=−2^26, b=−2^17 -> res_prod=+2^43. a=2^26−1, b=−2^17 -> res_prod=−(2^43−2^17).
- Reset mid-operation: assert rst_n=0 with 3 ops in flight -> res_valid=0 immediately (async). After release, no stale result appears and the first new grant goes to the lowest valid index.

Source files
------------

// File: rtl/mult_share_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mult_share_arb
// Round-robin arbiter/sequencer sharing one pipelined signed multiplier among
// NREQ requesters. A {valid,id} tag pipeline of depth LAT runs in lock-step
// with the multiplier (both advance only on m_ce). Each product is returned
// with the ID of the requester that issued it. Result backpressure freezes
// the multiplier and the tag pipeline through m_ce.
//
// Optional feature macro: MULT_SHARE_ARB_STATS_EN (saturating stall counter).
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   req_valid/ready   per-requester handshake, ready is the one-hot grant
//   req_a/req_b       packed signed operands, requester i at [i*W +: W]
//   m_ce/m_ain/m_bin  multiplier clock enable and operands
//   m_prod            multiplier product (LAT ce-enabled stages after ain/bin)
//   res_valid/ready   result handshake
//   res_id/res_prod   requester ID and full-width signed product
//   stall_cnt         stall cycles with pending requests (0 without macro)
// -----------------------------------------------------------------------------
module mult_share_arb #(
    parameter int AW   = 27,
    parameter int BW   = 18,
    parameter int NREQ = 4,
    parameter int LAT  = 3,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*AW-1:0]        req_a,
    input  logic [NREQ*BW-1:0]        req_b,
    output logic                      m_ce,
    output logic [AW-1:0]             m_ain,
    output logic [BW-1:0]             m_bin,
    input  logic signed [AW+BW-1:0]   m_prod,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [IDW-1:0]            res_id,
    output logic signed [AW+BW-1:0]   res_prod,
    output logic [31:0]               stall_cnt
);

    localparam int IW1 = IDW + 1;

    logic                 run_r;
    logic [IDW-1:0]       ptr_r;
    logic                 tag_v_r  [LAT];
    logic [IDW-1:0]       tag_id_r [LAT];
    logic                 stall_s;
    logic                 found_s;
    logic                 gnt_s;
    logic [IDW-1:0]       gnt_id_s;

    // Result side comes straight from the last tag stage and the multiplier.
    assign res_valid = tag_v_r[LAT-1];
    assign res_id    = tag_id_r[LAT-1];
    assign res_prod  = m_prod;

    // A held result freezes the whole datapath; run_r keeps ce low until the
    // first clock after reset release so nothing issues during release.
    assign stall_s = res_valid & ~res_ready;
    assign m_ce    = run_r & ~stall_s;
    assign gnt_s   = found_s & m_ce;

    // Reset-release flag: goes high on the first edge after rst_n deasserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Round-robin search from ptr upward with wrap. The loop runs from the
    // farthest offset down so the nearest valid requester wins.
    always_comb begin : arb_search
        logic [IW1-1:0] sum_v;
        sum_v    = '0;
        found_s  = 1'b0;
        gnt_id_s = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum_v = {1'b0, ptr_r} + IW1'(k);
            sum_v = (sum_v >= IW1'(NREQ)) ? (sum_v - IW1'(NREQ)) : sum_v;
            if (req_valid[sum_v[IDW-1:0]]) begin
                found_s  = 1'b1;
                gnt_id_s = sum_v[IDW-1:0];
            end else begin
                found_s  = found_s;
                gnt_id_s = gnt_id_s;
            end
        end
    end

    // One-hot ready and operand mux; operands are zero when nothing is granted.
    always_comb begin
        req_ready = '0;
        m_ain     = '0;
        m_bin     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s && (gnt_id_s == IDW'(i))) begin
                req_ready[i] = 1'b1;
                m_ain        = req_a[i*AW +: AW];
                m_bin        = req_b[i*BW +: BW];
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Round-robin pointer: moves past the winner only when a grant happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (gnt_s) begin
            if (gnt_id_s == IDW'(NREQ - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= gnt_id_s + IDW'(1);
            end
        end
    end

    // Tag pipeline mirrors the multiplier stages; clearing the valids on
    // reset discards whatever the multiplier still holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                tag_v_r[i]  <= 1'b0;
                tag_id_r[i] <= '0;
            end
        end else if (m_ce) begin
            tag_v_r[0] <= gnt_s;
            if (gnt_s) begin
                tag_id_r[0] <= gnt_id_s;
            end else begin
                tag_id_r[0] <= '0;
            end
            for (int i = 1; i < LAT; i++) begin
                tag_v_r[i]  <= tag_v_r[i-1];
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

`ifdef MULT_SHARE_ARB_STATS_EN
    logic [31:0] stall_cnt_r;

    // Counts stalled cycles while some requester is waiting; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (|req_valid) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mult_share_arb
// Directed bench for mult_share_arb with a behavioural LAT-stage multiplier.
// Each test pushes hand-computed {id, product} pairs into a queue; a monitor
// pops and compares on every accepted result. Handshake, stall and reset
// behaviour are checked inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_mult_share_arb;

    localparam int AW   = 27;
    localparam int BW   = 18;
    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam int IDW  = 2;
    localparam int PW   = AW + BW;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [PW-1:0]  prod;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*AW-1:0]      req_a;
    logic [NREQ*BW-1:0]      req_b;
    logic                    m_ce;
    logic signed [AW-1:0]    m_ain;
    logic signed [BW-1:0]    m_bin;
    logic signed [PW-1:0]    m_prod;
    logic                    res_valid;
    logic                    res_ready;
    logic [IDW-1:0]          res_id;
    logic signed [PW-1:0]    res_prod;
    logic [31:0]             stall_cnt;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q [$];

    int t1a [4] = '{3, -10, 7, 0};
    int t1b [4] = '{-4, 10, 7, 5};
    logic [3:0] t4v [4] = '{4'b0100, 4'b1010, 4'b1010, 4'b1010};
    logic [3:0] t4r [4] = '{4'b0100, 4'b1000, 4'b0010, 4'b1000};

    always #5 clk = ~clk;

    mult_share_arb #(.AW(AW), .BW(BW), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .m_ce      (m_ce),
        .m_ain     (m_ain),
        .m_bin     (m_bin),
        .m_prod    (m_prod),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_prod  (res_prod),
        .stall_cnt (stall_cnt)
    );

    // Behavioural multiplier: LAT ce-qualified stages, contents not reset.
    logic signed [PW-1:0] mp [LAT];
    always @(posedge clk) begin
        if (m_ce) begin
            mp[0] <= m_ain * m_bin;
            for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
        end
    end
    assign m_prod = mp[LAT-1];

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*AW +: AW] = AW'(a);
        req_b[i*BW +: BW] = BW'(b);
    endtask

    task automatic push(input int id, input longint p);
        exp_t e;
        e.id   = IDW'(id);
        e.prod = PW'(p);
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: a result transfers at the next edge when valid&ready.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got id=%0d prod=%0d expected none",
                         res_id, res_prod);
            end else begin
                e = exp_q.pop_front();
                chk("res_id", res_id, e.id);
                chk("res_prod", res_prod, $signed(e.prod));
            end
        end
    end

    // Assert reset now, check reset outputs, release, wait for ce to come up.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_m_ce"}, m_ce, 0);
        chk({tag, "_m_ain"}, m_ain, 0);
        chk({tag, "_m_bin"}, m_bin, 0);
        chk({tag, "_res_id"}, res_id, 0);
        chk({tag, "_stall_cnt"}, stall_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        logic [3:0] er;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;

        do_reset("rst0");

        // Single requester back-to-back, latency LAT, 4 consecutive results.
        push(0, -12); push(0, -100); push(0, 49); push(0, 0);
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                req_valid = 4'b0001;
                set_op(0, t1a[c], t1b[c]);
            end else begin
                req_valid = 4'b0000;
            end
            @(negedge clk);
            chk("t1_ready", req_ready, (c < 4) ? 4'b0001 : 4'b0000);
            chk("t1_latency", res_valid, (c >= 3 && c <= 6) ? 1 : 0);
            @(posedge clk); #1;
        end
        drain("t1_drain");

        // All requesters continuously valid: rotating grants from 0.
        do_reset("rst1");
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, -2);
        for (int r = 0; r < 2; r++) begin
            push(0, -2); push(1, -4); push(2, -6); push(3, -8);
        end
        for (int c = 0; c < 8; c++) begin
            req_valid = 4'b1111;
            er = 4'b0001 << (c % 4);
            @(negedge clk);
            chk("t2_ready", req_ready, er);
            @(posedge clk); #1;
        end
        req_valid = '0;
        drain("t2_drain");

        // Backpressure: 5 stalled cycles while the first result is valid.
        do_reset("rst2");
        for (int k = 0; k < 10; k++) push(2, 3 * (k + 1));
        n = 0;
        for (int c = 0; c < 40 && n < 10; c++) begin
            res_ready = !(c >= 3 && c <= 7);
            req_valid = 4'b0100;
            set_op(2, n + 1, 3);
            @(negedge clk);
            if (c >= 3 && c <= 7) begin
                chk("t3_stall_m_ce", m_ce, 0);
                chk("t3_stall_ready", req_ready, 0);
                chk("t3_stall_valid", res_valid, 1);
                chk("t3_stall_id", res_id, 2);
                chk("t3_stall_prod", res_prod, 3);
            end else begin
                chk("t3_ready", req_ready, 4'b0100);
            end
            if (req_ready[2]) n++;
            @(posedge clk); #1;
        end
        req_valid = '0;
        res_ready = 1'b1;
        chk("t3_issued", n, 10);
`ifdef MULT_SHARE_ARB_STATS_EN
        chk("t3_stall_cnt", stall_cnt, 5);
`else
        chk("t3_stall_cnt", stall_cnt, 0);
`endif
        drain("t3_drain");

        // Wrap: grant 2 moves ptr to 3; then requesters 1,3 -> 3,1,3.
        set_op(2, 1, 1); set_op(1, 2, 2); set_op(3, 3, 3);
        push(2, 1); push(3, 9); push(1, 4); push(3, 9);
        for (int c = 0; c < 4; c++) begin
            req_valid = t4v[c];
            @(negedge clk);
            chk("t4_ready", req_ready, t4r[c]);
            @(posedge clk); #1;
        end
        req_valid = '0;
        drain("t4_drain");

        // Operand extremes: +2^43 and -(2^43 - 2^17).
        push(1, 64'sd8796093022208);
        push(1, -64'sd8796092891136);
        req_valid = 4'b0010;
        set_op(1, -67108864, -131072);
        @(negedge clk);
        chk("t5_ready0", req_ready, 4'b0010);
        @(posedge clk); #1;
        set_op(1, 67108863, -131072);
        @(negedge clk);
        chk("t5_ready1", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        drain("t5_drain");

        // Reset with 3 ops in flight: nothing stale, first grant to lowest index.
        for (int i = 0; i < NREQ; i++) set_op(i, 100 + i, 100);
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b1111;
            @(posedge clk); #1;
        end
        req_valid = '0;
        chk("t6_inflight", res_valid, 1);
        do_reset("rst3");
        set_op(1, 6, 7);
        set_op(2, 5, 5);
        push(1, 42);
        req_valid = 4'b0110;
        @(negedge clk);
        chk("t6_first_grant", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

endmodule
